// File: rtl/validation_checker.sv
// validation_checker
//   Compares an engine result stream against expected words held in the validation memory.
//   For result i the expected word is read from base_addr+i (wrapping at 2^ADDR_W).
//   Mismatches are counted and the first failing address is recorded. A pass/fail verdict
//   is reported with a one-cycle done pulse when the run ends.
//
//   Optional feature: define TOLERANCE_EN to accept |signed(res)-signed(exp)| <= TOL as a
//   match. When it is undefined, a match requires bitwise equality.
//
// Ports
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   start                  one-cycle run request; ignored while a run is in progress
//   base_addr, num_samples first expected-word address and run length, latched on start
//   res_data/valid/ready   result stream from the engine (valid/ready handshake)
//   mem_addr, mem_rd_en    read request to the validation memory; mem_wr_en is tied low
//   mem_data, mem_ready    read data and its valid pulse from the validation memory
//   busy, done             run in progress / one-cycle end-of-run pulse
//   pass, timeout          verdict of the last run
//   err_count              number of mismatches in the last run
//   first_err_addr         address of the first mismatch (0 if none)
module validation_checker #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 11,
`ifdef TOLERANCE_EN
    parameter int unsigned TOL     = 2,
`endif
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_samples,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_valid,
    output logic              res_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitRes,
        StReq,
        StWaitMem,
        StCmp,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [DATA_W-1:0] res_cap_q, res_cap_d;
    logic [DATA_W-1:0] mem_cap_q, mem_cap_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic              res_ready_d, mem_rd_en_d, busy_d, done_d, pass_d, timeout_d;
    logic [ADDR_W-1:0] mem_addr_d, first_err_d;
    logic [ADDR_W:0]   err_count_d;

    logic              res_fire;
    logic              wait_expired;
    logic              last_sample;
    logic              is_match;

    assign mem_wr_en    = 1'b0;
    assign res_fire     = res_valid && res_ready;
    assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign last_sample  = ((idx_q + 1'b1) == num_q);

`ifdef TOLERANCE_EN
    // Sign-extend by one bit so the difference of any two DATA_W values cannot overflow.
    logic [DATA_W:0] diff;
    logic [DATA_W:0] abs_diff;
    assign diff     = {res_cap_q[DATA_W-1], res_cap_q} - {mem_cap_q[DATA_W-1], mem_cap_q};
    assign abs_diff = diff[DATA_W] ? (~diff + 1'b1) : diff;
    assign is_match = (abs_diff <= (DATA_W + 1)'(TOL));
`else
    assign is_match = (res_cap_q == mem_cap_q);
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (num_samples == '0) ? StDone : StWaitRes;
                end
            end
            StWaitRes: begin
                if (res_fire) begin
                    state_d = StReq;
                end
            end
            StReq: state_d = StWaitMem;
            StWaitMem: begin
                if (mem_ready) begin
                    state_d = StCmp;
                end else if (wait_expired) begin
                    state_d = StDone;
                end
            end
            StCmp:  state_d = last_sample ? StDone : StWaitRes;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values. Outputs are decoded from state_d and registered so
    // that each one lines up with the state it belongs to.
    always_comb begin
        base_d      = base_q;
        num_d       = num_q;
        idx_d       = idx_q;
        res_cap_d   = res_cap_q;
        mem_cap_d   = mem_cap_q;
        wait_cnt_d  = wait_cnt_q;
        mem_addr_d  = mem_addr;
        err_count_d = err_count;
        first_err_d = first_err_addr;
        pass_d      = pass;
        timeout_d   = timeout;

        res_ready_d = (state_d == StWaitRes);
        mem_rd_en_d = (state_d == StReq);
        busy_d      = (state_d == StWaitRes) || (state_d == StReq) ||
                      (state_d == StWaitMem) || (state_d == StCmp);
        done_d      = (state_d == StDone);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d      = base_addr;
                    num_d       = num_samples;
                    idx_d       = '0;
                    err_count_d = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            StWaitRes: begin
                if (res_fire) begin
                    res_cap_d  = res_data;
                    // Wraps naturally at 2^ADDR_W.
                    mem_addr_d = base_q + idx_q[ADDR_W-1:0];
                end
            end
            StReq: wait_cnt_d = '0;
            StWaitMem: begin
                if (mem_ready) begin
                    mem_cap_d = mem_data;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StCmp: begin
                if (!is_match) begin
                    err_count_d = err_count + 1'b1;
                    if (err_count == '0) begin
                        first_err_d = mem_addr;
                    end
                end
                idx_d = idx_q + 1'b1;
            end
            default: ;
        endcase

        // The verdict appears together with the done pulse.
        if ((state_d == StDone) && (state_q != StDone)) begin
            pass_d = (err_count_d == '0) && !timeout_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q         <= '0;
            num_q          <= '0;
            idx_q          <= '0;
            res_cap_q      <= '0;
            mem_cap_q      <= '0;
            wait_cnt_q     <= '0;
            res_ready      <= 1'b0;
            mem_addr       <= '0;
            mem_rd_en      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            base_q         <= base_d;
            num_q          <= num_d;
            idx_q          <= idx_d;
            res_cap_q      <= res_cap_d;
            mem_cap_q      <= mem_cap_d;
            wait_cnt_q     <= wait_cnt_d;
            res_ready      <= res_ready_d;
            mem_addr       <= mem_addr_d;
            mem_rd_en      <= mem_rd_en_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            timeout        <= timeout_d;
            err_count      <= err_count_d;
            first_err_addr <= first_err_d;
        end
    end

endmodule

// File: tb/tb_validation_checker.sv
// Testbench for validation_checker: table of directed runs, timeout and reset sequences,
// then randomized runs checked against a behavioural model of the run result.
module tb_validation_checker;

    localparam int TIMEOUT = 15;
    localparam int TOL     = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] base_addr = '0;
    logic [11:0] num_samples = '0;
    logic [15:0] res_data = '0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [10:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [15:0] mem_data = '0;
    logic        mem_ready = 1'b0;
    logic        busy, done, pass, timeout;
    logic [11:0] err_count;
    logic [10:0] first_err_addr;

    validation_checker dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_samples    (num_samples),
        .res_data       (res_data),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_wr_en      (mem_wr_en),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    // Shared stimulus state: main thread fills the queues, then bumps gen to publish them.
    logic [15:0] tb_mem [2048];
    logic [15:0] feed_q[$];
    int          lat_q[$];
    int          gen = 0;
    bit          gaps = 1'b0;
    logic [10:0] rd_log[$];
    int          done_total = 0;
    bit          wr_seen = 1'b0;

    int total = 0;
    int bad   = 0;

    // Result source
    always @(posedge clk) begin : feeder
        int f_idx;
        int f_gen;
        if (f_gen != gen) begin
            f_gen = gen;
            f_idx = 0;
        end else if (res_valid && res_ready) begin
            f_idx++;
        end
        if (reset_n && f_idx < feed_q.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
            res_valid <= 1'b1;
            res_data  <= feed_q[f_idx];
        end else begin
            res_valid <= 1'b0;
            res_data  <= 16'($urandom);
        end
    end

    // Validation memory: answers each read after lat_q[k] extra cycles.
    always @(posedge clk or negedge reset_n) begin : responder
        int          l_idx;
        int          l_gen;
        int          l;
        int          pend;
        logic [15:0] pend_data;
        if (!reset_n) begin
            pend = 0;
            mem_ready <= 1'b0;
        end else begin
            if (l_gen != gen) begin
                l_gen = gen;
                l_idx = 0;
            end
            mem_ready <= 1'b0;
            mem_data  <= 16'($urandom);
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_ready <= 1'b1;
                    mem_data  <= pend_data;
                end
            end
            if (mem_rd_en) begin
                rd_log.push_back(mem_addr);
                l = (l_idx < lat_q.size()) ? lat_q[l_idx] : 0;
                l_idx++;
                if (l == 0) begin
                    mem_ready <= 1'b1;
                    mem_data  <= tb_mem[mem_addr];
                end else begin
                    pend      = l;
                    pend_data = tb_mem[mem_addr];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (done) done_total++;
        if (mem_wr_en) wr_seen = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, 32'({res_ready, mem_rd_en, mem_wr_en, busy, done, pass, timeout}), 0);
        chk({nm, "_addr"}, 32'(mem_addr), 0);
        chk({nm, "_errcnt"}, 32'(err_count), 0);
        chk({nm, "_first"}, 32'(first_err_addr), 0);
    endtask

    function automatic bit model_match(input logic [15:0] r, input logic [15:0] m);
`ifdef TOLERANCE_EN
        int d;
        d = int'($signed(r)) - int'($signed(m));
        return (d <= TOL) && (d >= -TOL);
`else
        return r == m;
`endif
    endfunction

    // Runs one checker pass using feed_q/lat_q (n entries each) and checks it against the model.
    task automatic exec_run(input string nm, input logic [10:0] base, input int n,
                            input bit inj, input bit fast);
        int          e_err;
        logic [10:0] e_first;
        bit          e_to;
        logic [10:0] e_addrs[$];
        logic [10:0] a;
        int          cyc, d0, r0;
        bit          ok;
        e_err = 0; e_first = '0; e_to = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = base + 11'(i);
            e_addrs.push_back(a);
            if (lat_q[i] >= TIMEOUT) begin
                e_to = 1'b1;
                break;
            end
            if (!model_match(feed_q[i], tb_mem[a])) begin
                if (e_err == 0) e_first = a;
                e_err++;
            end
        end

        gen++;
        d0 = done_total;
        r0 = rd_log.size();
        @(negedge clk);
        base_addr = base; num_samples = 12'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 30000) begin
            if (inj && cyc == 3) begin
                start = 1'b1; base_addr = ~base; num_samples = 12'd7;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (done !== 1'b1) begin
            chk({nm, "_done_seen"}, 0, 1);
        end else begin
            chk({nm, "_err_count"}, 32'(err_count), 32'(e_err));
            chk({nm, "_first_err"}, 32'(first_err_addr), 32'(e_first));
            chk({nm, "_pass"}, 32'(pass), 32'((e_err == 0) && !e_to));
            chk({nm, "_timeout"}, 32'(timeout), 32'(e_to));
            chk({nm, "_busy_at_done"}, 32'(busy), 0);
            if (fast) chk({nm, "_latency"}, 32'(cyc), 32'((n == 0) ? 1 : 4 * n + 1));
            ok = ((rd_log.size() - r0) == e_addrs.size());
            for (int i = 0; ok && i < e_addrs.size(); i++) begin
                if (rd_log[r0 + i] !== e_addrs[i]) ok = 1'b0;
            end
            chk({nm, "_rd_addrs"}, 32'(ok), 1);
            if (inj) begin
                // Start during the done cycle must be dropped.
                start = 1'b1; base_addr = '0; num_samples = 12'd1;
                @(negedge clk);
                start = 1'b0;
            end
            repeat (3) @(negedge clk);
            chk({nm, "_done_count"}, 32'(done_total - d0), 1);
            chk({nm, "_idle_after"}, 32'(busy), 0);
            chk({nm, "_hold_err"}, 32'(err_count), 32'(e_err));
        end
    endtask

    typedef struct {
        logic [10:0]      base;
        int               n;
        logic [0:3][15:0] mw;
        logic [0:3][15:0] rw;
        int               e_err;
        logic [10:0]      e_first;
        bit               e_pass;
        bit               inj;
    } vec_t;

    vec_t        vecs[7];
    logic [10:0] rb;
    int          rn, d0, k;
    logic [15:0] m, rv;

    initial begin
        vecs[0] = '{11'd100, 4, {16'd5, 16'd6, 16'd7, 16'd8}, {16'd5, 16'd6, 16'd7, 16'd8},
                    0, 11'd0, 1'b1, 1'b1};
        vecs[1] = '{11'd100, 4, {16'd5, 16'd6, 16'd7, 16'd8}, {16'd5, 16'd9, 16'd7, 16'd0},
                    2, 11'd101, 1'b0, 1'b0};
        vecs[2] = '{11'd2046, 4, {16'd1, 16'd2, 16'd3, 16'd4}, {16'd1, 16'd2, 16'd3, 16'd9},
                    1, 11'd1, 1'b0, 1'b0};
        vecs[3] = '{11'd7, 0, {16'd0, 16'd0, 16'd0, 16'd0}, {16'd0, 16'd0, 16'd0, 16'd0},
                    0, 11'd0, 1'b1, 1'b0};
`ifdef TOLERANCE_EN
        vecs[4] = '{11'd500, 1, {16'h7FFF, 16'd0, 16'd0, 16'd0}, {16'h7FFD, 16'd0, 16'd0, 16'd0},
                    0, 11'd0, 1'b1, 1'b0};
`else
        vecs[4] = '{11'd500, 1, {16'h7FFF, 16'd0, 16'd0, 16'd0}, {16'h7FFD, 16'd0, 16'd0, 16'd0},
                    1, 11'd500, 1'b0, 1'b0};
`endif
        vecs[5] = '{11'd500, 1, {16'h7FFF, 16'd0, 16'd0, 16'd0}, {16'h8000, 16'd0, 16'd0, 16'd0},
                    1, 11'd500, 1'b0, 1'b0};
        vecs[6] = '{11'd2047, 2, {16'h8000, 16'd0, 16'd0, 16'd0}, {16'h7FFF, 16'd0, 16'd0, 16'd0},
                    1, 11'd2047, 1'b0, 1'b0};

        for (int i = 0; i < 2048; i++) tb_mem[i] = 16'($urandom);

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table
        gaps = 1'b0;
        for (int v = 0; v < 7; v++) begin
            feed_q.delete(); lat_q.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                tb_mem[vecs[v].base + 11'(i)] = vecs[v].mw[i];
                feed_q.push_back(vecs[v].rw[i]);
                lat_q.push_back(0);
            end
            exec_run($sformatf("vec%0d", v), vecs[v].base, vecs[v].n, vecs[v].inj, 1'b1);
            chk($sformatf("vec%0d_tbl_err", v), 32'(err_count), 32'(vecs[v].e_err));
            chk($sformatf("vec%0d_tbl_first", v), 32'(first_err_addr), 32'(vecs[v].e_first));
            chk($sformatf("vec%0d_tbl_pass", v), 32'(pass), 32'(vecs[v].e_pass));
        end

        // Mismatch, then timeout on the third read
        feed_q.delete(); lat_q.delete();
        for (int i = 0; i < 3; i++) begin
            feed_q.push_back(tb_mem[11'd300 + 11'(i)] ^ ((i == 1) ? 16'h0100 : 16'h0000));
        end
        lat_q = '{0, 0, 15};
        exec_run("timeout_run", 11'd300, 3, 1'b0, 1'b0);
        chk("timeout_flag", 32'(timeout), 1);

        // mem_ready in the last allowed wait cycle is still accepted
        feed_q.delete(); lat_q.delete();
        feed_q.push_back(tb_mem[11'd900]); feed_q.push_back(tb_mem[11'd901]);
        lat_q = '{14, 0};
        exec_run("late_ready", 11'd900, 2, 1'b0, 1'b0);

        // Reset in the middle of a run
        feed_q.delete(); lat_q.delete();
        for (int i = 0; i < 4; i++) begin
            feed_q.push_back(tb_mem[11'd10 + 11'(i)] + 16'd100);
            lat_q.push_back(0);
        end
        gen++;
        @(negedge clk);
        base_addr = 11'd10; num_samples = 12'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = done_total;
        repeat (6) @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_total - d0), 0);
        chk_zero("rst_after");

        // Full-size run with address wrap and minimum throughput
        feed_q.delete(); lat_q.delete();
        rb = 11'($urandom);
        for (int i = 0; i < 2048; i++) begin
            m = tb_mem[rb + 11'(i)];
            feed_q.push_back((i % 700 == 5) ? ~m : m);
            lat_q.push_back(0);
        end
        exec_run("full_2048", rb, 2048, 1'b0, 1'b1);

        // Randomized runs
        gaps = 1'b1;
        for (int r = 0; r < 25; r++) begin
            feed_q.delete(); lat_q.delete();
            rb = 11'($urandom);
            rn = $urandom_range(0, 20);
            for (int i = 0; i < rn; i++) begin
                m = 16'($urandom);
                tb_mem[rb + 11'(i)] = m;
                k = $urandom_range(0, 7);
                if (k == 0) rv = m + 16'($urandom_range(1, 3));
                else if (k == 1) rv = m - 16'($urandom_range(1, 3));
                else if (k == 2) rv = 16'($urandom);
                else rv = m;
                feed_q.push_back(rv);
                lat_q.push_back($urandom_range(0, 3));
            end
            if (r % 6 == 5 && rn > 0) lat_q[$urandom_range(0, rn - 1)] = 15 + $urandom_range(0, 1);
            exec_run($sformatf("rand%0d", r), rb, rn, (r % 7 == 3), 1'b0);
        end

        chk("wr_en_never", 32'(wr_seen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
